spi_slave_frame_rx: RTL and testbench
=====================================

// Module: spi_slave_frame_rx
// PURPOSE
//  SPI mode-0 slave receiver: oversamples SCLK/MOSI/n_SS in the system clock domain,
//  assembles 2-byte frames (MSB first) into a 14-bit counter value for the FND display path.
//  Sits between the external slave SPI pins and the FND controller in the slave top;
//  consumes the frames the master-side up-counter transmits.
// PARAMETERS
//  SYNC_STAGES  2     synchronizer flops on SCLK, MOSI and n_SS (min 2)
//  DATA_W       14    width of assembled value (low 14 bits of the 16-bit frame)
//  MAX_VALUE    9999  largest legal value; larger frames are rejected
// PORTS
//  clk          in   1       system clock; SCLK must be <= clk/8
//  reset        in   1       asynchronous, active-high reset
//  SCLK         in   1       SPI serial clock from master, idle low (CPOL=0)
//  MOSI         in   1       serial data from master
//  MISO         out  1       serial data to master (see CONFIGURATION)
//  n_SS         in   1       active-low slave select
//  rx_value     out  DATA_W  last accepted value, held until next accepted frame
//  rx_valid     out  1       1-clk pulse when rx_value updates
//  frame_err    out  1       1-clk pulse when a complete frame is rejected (> MAX_VALUE)
// BEHAVIOUR
//  - Reset: rx_value=0, rx_valid=0, frame_err=0, MISO=0, state IDLE, shift reg/bit count=0.
//  - Inputs pass SYNC_STAGES flops; SCLK rise/fall detected by comparing last two sync stages.
//  - Mode 0: MOSI sampled on synchronized SCLK rise; MISO updated on synchronized SCLK fall.
//  - FSM: IDLE -> SHIFT when synced n_SS=0; SHIFT counts 16 rises (bit_cnt 0..15);
//    on 16th rise -> CHECK (one clk) -> SHIFT if n_SS still 0, else IDLE.
//  - CHECK: frame = {byte0,byte1}; bits[15:14] ignored; if frame[13:0] <= MAX_VALUE then
//    rx_value<=frame[13:0], rx_valid=1 else frame_err=1, rx_value unchanged.
//  - Latency: rx_valid asserts SYNC_STAGES+2 clks after the physical 16th SCLK rise.
//  - Back-to-back frames under one n_SS low: bit_cnt wraps 15->0; next frame starts cleanly.
//  - n_SS rises mid-frame (bit_cnt 1..15): partial frame discarded, no pulse, bit_cnt=0, IDLE.
//  - SCLK edges while synced n_SS=1: ignored.
//  - n_SS rising in same clk as CHECK: frame still evaluated, then IDLE.
//  - rx_valid and frame_err never assert together; each exactly one clk per frame.
//  - Async reset mid-frame: all state cleared immediately; next frame needs fresh n_SS fall.
// CONFIGURATION
//  SPI_RX_ECHO_EN defined: MISO shifts out the last accepted 16-bit frame, MSB first,
//    loaded at n_SS fall (IDLE->SHIFT) and at CHECK; bit 15 driven before first SCLK rise,
//    next bit on each SCLK fall; MISO=0 while n_SS high.
//  SPI_RX_ECHO_EN undefined: MISO tied to 0; no transmit shift register synthesized.
// TESTING
//  1) Reset, send 0x04D2 (1234) in one n_SS window -> rx_value=1234, one rx_valid pulse.
//  2) Two frames 0x0000 then 0x270F under one n_SS low -> two pulses; rx_value 0 then 9999.
//  3) Frame 0x2710 (10000) after 1234 -> frame_err pulse, rx_value stays 1234, no rx_valid.
//  4) n_SS rises after 9 bits of 0x0005, then full 0x0007 -> no pulse for partial; rx_value=7.
//  5) Frame 0xC00A -> top bits ignored, rx_value=10; reset asserted mid-next-frame -> rx_value=0.
//  6) ECHO_EN: after accepting 0x0123, next frame's MISO bits sampled on rise read 0x0123;
//     without ECHO_EN MISO stays 0 throughout.

Source files
------------

// File: rtl/spi_slave_frame_rx.sv
// spi_slave_frame_rx
// SPI mode-0 slave receiver. SCLK, MOSI and n_SS are oversampled in the clk
// domain. Two bytes are assembled MSB first into one 16-bit frame. The low
// DATA_W bits are published on rx_value when they do not exceed MAX_VALUE.
// Larger frames are rejected with a frame_err pulse.
//
// Ports
//   clk        system clock (SCLK must be at most clk/8)
//   reset      asynchronous, active-high reset
//   SCLK       SPI clock from the master, idle low
//   MOSI       serial data from the master
//   MISO       serial data to the master (echo option, otherwise 0)
//   n_SS       active-low slave select
//   rx_value   last accepted value, held until the next accepted frame
//   rx_valid   one-clk pulse when rx_value updates
//   frame_err  one-clk pulse when a complete frame is rejected
//
// Configuration macro
//   SPI_RX_ECHO_EN  when defined, MISO shifts out the last accepted 16-bit
//                   frame MSB first. When undefined, MISO is tied to 0.
module spi_slave_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 14,
  parameter int MAX_VALUE   = 9999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              n_SS,
  output logic [DATA_W-1:0] rx_value,
  output logic              rx_valid,
  output logic              frame_err
);

`ifdef SPI_RX_ECHO_EN
  // The echo path needs the whole frame, including the ignored top bits.
  localparam int FRAME_W = 16;
`else
  localparam int FRAME_W = DATA_W;
`endif

  localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX_VALUE);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t               state;
  logic [3:0]           bit_cnt;
  logic [FRAME_W-1:0]   shift_reg;

  // SCLK and n_SS get one extra stage so that edges can be detected by
  // comparing the last two stages. The data stage SYNC_STAGES-1 lines up
  // with MOSI.
  logic [SYNC_STAGES:0]   sclk_sync;
  logic [SYNC_STAGES:0]   ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;

  logic sclk_rise;
  logic ss_low;
  logic ss_fall;
  logic mosi_s;
  logic frame_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-1:0], n_SS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_sync[SYNC_STAGES];
  assign ss_low    = ~ss_sync[SYNC_STAGES-1];
  // After reset the n_SS chain reads 0. An n_SS that is held low through
  // reset therefore never shows a fall, and a fresh select is required.
  assign ss_fall   = ss_sync[SYNC_STAGES] & ~ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign frame_ok  = (shift_reg[DATA_W-1:0] <= MAX_V);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_value  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (ss_fall) state <= SHIFT;
        end
        SHIFT: begin
          if (!ss_low) begin
            // A deselect mid-frame drops the partial frame.
            state   <= IDLE;
            bit_cnt <= '0;
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[FRAME_W-2:0], mosi_s};
            if (bit_cnt == 4'd15) begin
              bit_cnt <= '0;
              state   <= CHECK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        CHECK: begin
          if (frame_ok) begin
            rx_value <= shift_reg[DATA_W-1:0];
            rx_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          state <= ss_low ? SHIFT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_RX_ECHO_EN
  logic [15:0] tx_reg;
  logic [15:0] last_frame;
  logic        sclk_fall;

  assign sclk_fall = sclk_sync[SYNC_STAGES] & ~sclk_sync[SYNC_STAGES-1];
  assign MISO      = tx_reg[15];

  // tx_reg is loaded when a frame window opens and at every frame boundary.
  // The SCLK fall that follows the 16th rise (bit_cnt back at 0) must not
  // shift, because bit 15 of the next frame is already presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_reg     <= '0;
      last_frame <= '0;
    end else begin
      case (state)
        IDLE:  tx_reg <= ss_fall ? last_frame : 16'h0000;
        SHIFT: begin
          if (!ss_low) tx_reg <= '0;
          else if (sclk_fall && bit_cnt != 4'd0) tx_reg <= {tx_reg[14:0], 1'b0};
        end
        CHECK: begin
          if (frame_ok) last_frame <= shift_reg;
          if (!ss_low) tx_reg <= '0;
          else         tx_reg <= frame_ok ? shift_reg : last_frame;
        end
        default: tx_reg <= '0;
      endcase
    end
  end
`else
  assign MISO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_frame_rx.sv
// tb_spi_slave_frame_rx
// Directed bench for spi_slave_frame_rx. Frames are bit-banged in SPI mode 0
// with SCLK at clk/10. The result each complete frame should produce is
// queued when its 16th SCLK rise is driven. A monitor pops and compares an
// entry whenever the DUT pulses rx_valid or frame_err.
module tb_spi_slave_frame_rx;

  logic        clk;
  logic        reset;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic        n_SS;
  logic [13:0] rx_value;
  logic        rx_valid;
  logic        frame_err;

  typedef struct {
    bit          is_err;
    logic [13:0] value;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        popped;
  int          total = 0;
  int          bad   = 0;
  logic [13:0] held_value = '0;
  logic [15:0] last_acc   = '0;

  spi_slave_frame_rx dut (
    .clk       (clk),
    .reset     (reset),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .n_SS      (n_SS),
    .rx_value  (rx_value),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The scoreboard pops one entry for every result pulse.
  always @(negedge clk) begin
    if (!reset && (rx_valid || frame_err)) begin
      total++;
      assert ((rx_valid && frame_err) === 1'b0) else begin
        bad++;
        $error("[TB] FAIL both_pulses observed=valid%0b_err%0b expected=one", rx_valid, frame_err);
      end
      total++;
      assert ((exp_q.size() > 0) === 1'b1) else begin
        bad++;
        $error("[TB] FAIL unexpected_pulse observed=valid%0b_err%0b expected=none", rx_valid, frame_err);
      end
      if (exp_q.size() > 0) begin
        popped = exp_q.pop_front();
        total++;
        assert (rx_valid === !popped.is_err) else begin
          bad++;
          $error("[TB] FAIL pulse_kind observed=valid%0b expected=valid%0b", rx_valid, !popped.is_err);
        end
        total++;
        assert (rx_value === popped.value) else begin
          bad++;
          $error("[TB] FAIL sb_value observed=%0d expected=%0d", rx_value, popped.value);
        end
      end
    end
  end

  function automatic logic miso_model(input int i);
`ifdef SPI_RX_ECHO_EN
    return last_acc[15-i];
`else
    return 1'b0;
`endif
  endfunction

  // end_mode: 0 keeps n_SS low, 1 raises it after the frame,
  // 2 raises it so that the synchronized rise lands on the CHECK clock.
  task automatic applyStimulus(input logic [15:0] f, input int nbits, input bit drop_ss, input int end_mode);
    if (drop_ss) n_SS = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = f[15-i];
      repeat (5) @(negedge clk);
      checkOutput("miso_bit", {31'd0, MISO}, {31'd0, miso_model(i)});
      SCLK = 1'b1;
      if (i == 15) begin
        if (f[13:0] <= 14'd9999) begin
          held_value = f[13:0];
          last_acc   = f;
          exp_q.push_back('{is_err: 1'b0, value: f[13:0]});
        end else begin
          exp_q.push_back('{is_err: 1'b1, value: held_value});
        end
        @(posedge clk);
        if (end_mode == 2) begin
          #2;
          n_SS = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("latency_early", {31'd0, rx_valid | frame_err}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("latency_hit", {31'd0, rx_valid | frame_err}, 32'd1);
        repeat (2) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
      SCLK = 1'b0;
    end
    if (end_mode == 1) begin
      repeat (5) @(negedge clk);
      n_SS = 1'b1;
    end
    if (end_mode != 0) begin
      repeat (10) @(negedge clk);
      checkOutput("miso_deselected", {31'd0, MISO}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    SCLK  = 1'b0;
    MOSI  = 1'b0;
    n_SS  = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("reset_value", {18'd0, rx_value}, 32'd0);
    checkOutput("reset_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_err",   {31'd0, frame_err}, 32'd0);
    checkOutput("reset_miso",  {31'd0, MISO}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Single frame of 1234.
    applyStimulus(16'h04D2, 16, 1'b1, 1);
    checkOutput("t1_value", {18'd0, rx_value}, 32'd1234);

    // Back-to-back frames under one select, including the 9999 boundary.
    applyStimulus(16'h0000, 16, 1'b1, 0);
    checkOutput("t2_value0", {18'd0, rx_value}, 32'd0);
    applyStimulus(16'h270F, 16, 1'b0, 1);
    checkOutput("t2_value1", {18'd0, rx_value}, 32'd9999);

    // 10000 is rejected and the previous value holds.
    applyStimulus(16'h04D2, 16, 1'b1, 1);
    applyStimulus(16'h2710, 16, 1'b1, 1);
    checkOutput("t3_hold", {18'd0, rx_value}, 32'd1234);

    // A partial frame is dropped, then a full frame is accepted.
    applyStimulus(16'h0005, 9, 1'b1, 1);
    checkOutput("t4_partial_hold", {18'd0, rx_value}, 32'd1234);
    applyStimulus(16'h0007, 16, 1'b1, 1);
    checkOutput("t4_value", {18'd0, rx_value}, 32'd7);

    // The top two bits are ignored. Reset is then applied mid-frame.
    applyStimulus(16'hC00A, 16, 1'b1, 1);
    checkOutput("t5_value", {18'd0, rx_value}, 32'd10);
    applyStimulus(16'h1234, 6, 1'b1, 0);
    reset = 1'b1;
    #1;
    checkOutput("t5_reset_value", {18'd0, rx_value}, 32'd0);
    checkOutput("t5_reset_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("t5_reset_miso",  {31'd0, MISO}, 32'd0);
    held_value = '0;
    last_acc   = '0;
    n_SS = 1'b1;
    MOSI = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // The echo of 0x0123 appears on MISO during the next frame.
    applyStimulus(16'h0123, 16, 1'b1, 1);
    checkOutput("t6_value0", {18'd0, rx_value}, 32'h0123);
    applyStimulus(16'h0AAA, 16, 1'b1, 1);
    checkOutput("t6_value1", {18'd0, rx_value}, 32'h0AAA);

    // An all-ones frame is rejected. n_SS then rises on the CHECK clock.
    applyStimulus(16'h3FFF, 16, 1'b1, 1);
    checkOutput("max_reject_hold", {18'd0, rx_value}, 32'h0AAA);
    applyStimulus(16'h0042, 16, 1'b1, 2);
    checkOutput("ss_at_check_value", {18'd0, rx_value}, 32'h0042);
    applyStimulus(16'h0099, 16, 1'b1, 1);
    checkOutput("after_check_rise", {18'd0, rx_value}, 32'h0099);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    checkOutput("sb_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
